// File: rtl/sdram_fifo_port_if.sv
// Signal bundle between the user/controller side and the SDRAM FIFO port.
// The slave modport is the port block itself; master drives its inputs.
interface sdram_fifo_port_if #(
    parameter int DATA_W = 16
);
    logic              usr_wr_en;
    logic [DATA_W-1:0] usr_wr_data;
    logic              usr_wr_full;
    logic              usr_rd_req;
    logic              usr_rd_en;
    logic [DATA_W-1:0] usr_rd_data;
    logic              usr_rd_valid;
    logic              usr_rd_empty;
    logic              wr_trig;
    logic              rd_trig;
    logic              wfifo_rd_en;
    logic [DATA_W-1:0] wfifo_rd_data;
    logic              wfifo_deepth_eight;
    logic              rfifo_wr_en;
    logic [DATA_W-1:0] rfifo_wr_data;
    logic              rfifo_full;
    logic              err_ovf;
    logic              err_udf;

    modport slave (
        input  usr_wr_en, usr_wr_data, usr_rd_req, usr_rd_en,
        input  wfifo_rd_en, rfifo_wr_en, rfifo_wr_data,
        output usr_wr_full, usr_rd_data, usr_rd_valid, usr_rd_empty,
        output wr_trig, rd_trig, wfifo_rd_data, wfifo_deepth_eight,
        output rfifo_full, err_ovf, err_udf
    );

    modport master (
        output usr_wr_en, usr_wr_data, usr_rd_req, usr_rd_en,
        output wfifo_rd_en, rfifo_wr_en, rfifo_wr_data,
        input  usr_wr_full, usr_rd_data, usr_rd_valid, usr_rd_empty,
        input  wr_trig, rd_trig, wfifo_rd_data, wfifo_deepth_eight,
        input  rfifo_full, err_ovf, err_udf
    );
endinterface

// File: rtl/sdram_fifo_port.sv
// User-side write/read FIFOs in front of an SDRAM controller, with burst
// trigger FSMs that request a controller burst whenever a burst can proceed.
module sdram_fifo_port #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 16,
    parameter int BURST  = 4
) (
    input  logic                sclk,
    input  logic                s_rst,
    sdram_fifo_port_if.slave    bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int BW = $clog2(BURST) + 1;

    typedef enum logic {W_IDLE, W_BUSY} wstate_e;
    typedef enum logic {R_IDLE, R_BUSY} rstate_e;

    logic [DATA_W-1:0] wmem_q [DEPTH];
    logic [DATA_W-1:0] rmem_q [DEPTH];

    logic [AW-1:0]     wwp_q, wwp_d, wrp_q, wrp_d;
    logic [AW-1:0]     rwp_q, rwp_d, rrp_q, rrp_d;
    logic [CW-1:0]     wcnt_q, wcnt_d, rcnt_q, rcnt_d;
    logic [3:0]        pending_q, pending_d;
    logic [BW-1:0]     wbeat_q, rbeat_q;
    wstate_e           wstate_q;
    rstate_e           rstate_q;
    logic [DATA_W-1:0] wfifo_rd_data_q, usr_rd_data_q;
    logic              usr_rd_valid_q, wr_trig_q, rd_trig_q;
    logic              err_ovf_q, err_udf_q;

    logic              w_push_s, w_pop_s, r_push_s, r_pop_s;
    logic              w_full_s, w_empty_s, r_full_s, r_empty_s;
    logic              rfifo_full_s, rd_issue_s;

    assign w_full_s     = (wcnt_q == CW'(DEPTH));
    assign w_empty_s    = (wcnt_q == {CW{1'b0}});
    assign r_full_s     = (rcnt_q == CW'(DEPTH));
    assign r_empty_s    = (rcnt_q == {CW{1'b0}});
    assign rfifo_full_s = (rcnt_q > CW'(DEPTH - BURST));

    assign w_push_s = bus.usr_wr_en   && !w_full_s;
    assign w_pop_s  = bus.wfifo_rd_en && !w_empty_s;
    assign r_push_s = bus.rfifo_wr_en && !r_full_s;
    assign r_pop_s  = bus.usr_rd_en   && !r_empty_s;

    // Issue only from idle so at most one read burst is outstanding at the controller
    assign rd_issue_s = (rstate_q == R_IDLE) && (pending_q != 4'd0) && !rfifo_full_s;

    assign bus.usr_wr_full        = w_full_s;
    assign bus.wfifo_deepth_eight = (32'(wcnt_q) >= 32'd8);
    assign bus.usr_rd_empty       = r_empty_s;
    assign bus.rfifo_full         = rfifo_full_s;
    assign bus.wfifo_rd_data      = wfifo_rd_data_q;
    assign bus.usr_rd_data        = usr_rd_data_q;
    assign bus.usr_rd_valid       = usr_rd_valid_q;
    assign bus.wr_trig            = wr_trig_q;
    assign bus.rd_trig            = rd_trig_q;
    assign bus.err_ovf            = err_ovf_q;
    assign bus.err_udf            = err_udf_q;

    // Next-state pointers, occupancy counts and pending-request count
    always_comb begin
        wwp_d = w_push_s ? wwp_q + AW'(1) : wwp_q;
        wrp_d = w_pop_s  ? wrp_q + AW'(1) : wrp_q;
        rwp_d = r_push_s ? rwp_q + AW'(1) : rwp_q;
        rrp_d = r_pop_s  ? rrp_q + AW'(1) : rrp_q;
        case ({w_push_s, w_pop_s})
            2'b10:   wcnt_d = wcnt_q + CW'(1);
            2'b01:   wcnt_d = wcnt_q - CW'(1);
            default: wcnt_d = wcnt_q;
        endcase
        case ({r_push_s, r_pop_s})
            2'b10:   rcnt_d = rcnt_q + CW'(1);
            2'b01:   rcnt_d = rcnt_q - CW'(1);
            default: rcnt_d = rcnt_q;
        endcase
        // A request arriving on the issue cycle cancels the decrement
        case ({rd_issue_s, bus.usr_rd_req})
            2'b10:   pending_d = pending_q - 4'd1;
            2'b01:   pending_d = (pending_q == 4'd15) ? pending_q : pending_q + 4'd1;
            default: pending_d = pending_q;
        endcase
    end

    // Storage arrays; contents are don't-care after reset, so no reset here
    always_ff @(posedge sclk) begin
        if (w_push_s) wmem_q[wwp_q] <= bus.usr_wr_data;
        if (r_push_s) rmem_q[rwp_q] <= bus.rfifo_wr_data;
    end

    // Pointer/count state, popped-word registers and sticky error flags
    always_ff @(posedge sclk or posedge s_rst) begin
        if (s_rst) begin
            wwp_q           <= '0;
            wrp_q           <= '0;
            rwp_q           <= '0;
            rrp_q           <= '0;
            wcnt_q          <= '0;
            rcnt_q          <= '0;
            pending_q       <= 4'd0;
            wfifo_rd_data_q <= '0;
            usr_rd_data_q   <= '0;
            usr_rd_valid_q  <= 1'b0;
            err_ovf_q       <= 1'b0;
            err_udf_q       <= 1'b0;
        end else begin
            wwp_q          <= wwp_d;
            wrp_q          <= wrp_d;
            rwp_q          <= rwp_d;
            rrp_q          <= rrp_d;
            wcnt_q         <= wcnt_d;
            rcnt_q         <= rcnt_d;
            pending_q      <= pending_d;
            usr_rd_valid_q <= r_pop_s;
            if (w_pop_s) wfifo_rd_data_q <= wmem_q[wrp_q];
            if (r_pop_s) usr_rd_data_q   <= rmem_q[rrp_q];
            err_ovf_q <= err_ovf_q | (bus.usr_wr_en && w_full_s)
                                   | (bus.rfifo_wr_en && r_full_s);
            err_udf_q <= err_udf_q | (bus.wfifo_rd_en && w_empty_s)
                                   | (bus.usr_rd_en && r_empty_s);
        end
    end

    // Write-burst FSM: one wr_trig per BURST words, then wait for BURST pops
    always_ff @(posedge sclk or posedge s_rst) begin
        if (s_rst) begin
            wstate_q  <= W_IDLE;
            wbeat_q   <= '0;
            wr_trig_q <= 1'b0;
        end else begin
            case (wstate_q)
                W_IDLE: begin
                    if (wcnt_q >= CW'(BURST)) begin
                        wr_trig_q <= 1'b1;
                        wbeat_q   <= '0;
                        wstate_q  <= W_BUSY;
                    end else begin
                        wr_trig_q <= 1'b0;
                    end
                end
                W_BUSY: begin
                    wr_trig_q <= 1'b0;
                    if (bus.wfifo_rd_en) begin
                        if (wbeat_q == BW'(BURST - 1)) begin
                            wbeat_q  <= '0;
                            wstate_q <= W_IDLE;
                        end else begin
                            wbeat_q <= wbeat_q + BW'(1);
                        end
                    end
                end
                default: begin
                    wr_trig_q <= 1'b0;
                    wstate_q  <= W_IDLE;
                end
            endcase
        end
    end

    // Read-burst FSM: issue a pending request, then wait for BURST pushes
    always_ff @(posedge sclk or posedge s_rst) begin
        if (s_rst) begin
            rstate_q  <= R_IDLE;
            rbeat_q   <= '0;
            rd_trig_q <= 1'b0;
        end else begin
            case (rstate_q)
                R_IDLE: begin
                    if (rd_issue_s) begin
                        rd_trig_q <= 1'b1;
                        rbeat_q   <= '0;
                        rstate_q  <= R_BUSY;
                    end else begin
                        rd_trig_q <= 1'b0;
                    end
                end
                R_BUSY: begin
                    rd_trig_q <= 1'b0;
                    if (bus.rfifo_wr_en) begin
                        if (rbeat_q == BW'(BURST - 1)) begin
                            rbeat_q  <= '0;
                            rstate_q <= R_IDLE;
                        end else begin
                            rbeat_q <= rbeat_q + BW'(1);
                        end
                    end
                end
                default: begin
                    rd_trig_q <= 1'b0;
                    rstate_q  <= R_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_sdram_fifo_port.sv
// Directed self-checking bench for sdram_fifo_port (DATA_W=16, DEPTH=16, BURST=4).
module tb_sdram_fifo_port;
    logic sclk;
    logic s_rst;
    int   n_pass;
    int   n_total;
    int   n_fail;
    logic [15:0] rq[$];
    logic [15:0] exp_w;
    logic [15:0] wv [4];

    sdram_fifo_port_if #(.DATA_W(16)) bus ();

    sdram_fifo_port #(.DATA_W(16), .DEPTH(16), .BURST(4)) dut (
        .sclk  (sclk),
        .s_rst (s_rst),
        .bus   (bus)
    );

    initial sclk = 1'b0;
    always #5 sclk = ~sclk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge sclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wpush(input logic [15:0] d);
        bus.usr_wr_en = 1'b1; bus.usr_wr_data = d; tick(); bus.usr_wr_en = 1'b0;
    endtask
    task automatic wpop();
        bus.wfifo_rd_en = 1'b1; tick(); bus.wfifo_rd_en = 1'b0;
    endtask
    task automatic rpush(input logic [15:0] d);
        bus.rfifo_wr_en = 1'b1; bus.rfifo_wr_data = d; tick(); bus.rfifo_wr_en = 1'b0;
    endtask
    task automatic rpop();
        bus.usr_rd_en = 1'b1; tick(); bus.usr_rd_en = 1'b0;
    endtask

    // Raise reset, check the asynchronous reset values, then release cleanly
    task automatic reset_and_check(input string tag);
        s_rst = 1'b1;
        #1;
        chk({tag, "_wr_full"}, 32'(bus.usr_wr_full), 32'd0);
        chk({tag, "_deep8"},   32'(bus.wfifo_deepth_eight), 32'd0);
        chk({tag, "_rd_empty"}, 32'(bus.usr_rd_empty), 32'd1);
        chk({tag, "_rfifo_full"}, 32'(bus.rfifo_full), 32'd0);
        chk({tag, "_wr_trig"}, 32'(bus.wr_trig), 32'd0);
        chk({tag, "_rd_trig"}, 32'(bus.rd_trig), 32'd0);
        chk({tag, "_rd_valid"}, 32'(bus.usr_rd_valid), 32'd0);
        chk({tag, "_rd_data"}, 32'(bus.usr_rd_data), 32'd0);
        chk({tag, "_wf_data"}, 32'(bus.wfifo_rd_data), 32'd0);
        chk({tag, "_err_ovf"}, 32'(bus.err_ovf), 32'd0);
        chk({tag, "_err_udf"}, 32'(bus.err_udf), 32'd0);
        tick();
        s_rst = 1'b0;
        tick();
        chk({tag, "_post_wr_trig"}, 32'(bus.wr_trig), 32'd0);
        chk({tag, "_post_rd_trig"}, 32'(bus.rd_trig), 32'd0);
    endtask

    initial begin
        n_pass = 0; n_total = 0; n_fail = 0;
        s_rst = 1'b0;
        bus.usr_wr_en = 1'b0; bus.usr_wr_data = 16'h0000;
        bus.usr_rd_req = 1'b0; bus.usr_rd_en = 1'b0;
        bus.wfifo_rd_en = 1'b0; bus.rfifo_wr_en = 1'b0; bus.rfifo_wr_data = 16'h0000;
        wv[0] = 16'h0F10; wv[1] = 16'h0F55; wv[2] = 16'h0FAA; wv[3] = 16'h0F01;
        #2;
        reset_and_check("rst0");

        // Basic write burst: trigger one cycle after the 4th word lands
        for (int i = 0; i < 4; i++) wpush(wv[i]);
        chk("wr_trig_early", 32'(bus.wr_trig), 32'd0);
        tick();
        chk("wr_trig_pulse", 32'(bus.wr_trig), 32'd1);
        tick();
        chk("wr_trig_single", 32'(bus.wr_trig), 32'd0);
        for (int i = 0; i < 4; i++) begin
            wpop();
            chk("burst_data", 32'(bus.wfifo_rd_data), 32'(wv[i]));
        end
        tick();
        chk("wr_trig_idle", 32'(bus.wr_trig), 32'd0);

        // Ten bursts through the write FIFO, wrapping the pointers
        for (int b = 0; b < 10; b++) begin
            for (int i = 0; i < 4; i++) wpush(16'h1000 + 16'(b * 4 + i));
            tick();
            chk("wrap_trig", 32'(bus.wr_trig), 32'd1);
            for (int i = 0; i < 4; i++) begin
                wpop();
                chk("wrap_data", 32'(bus.wfifo_rd_data), 32'h1000 + 32'(b * 4 + i));
            end
        end
        chk("wrap_err_ovf", 32'(bus.err_ovf), 32'd0);
        chk("wrap_err_udf", 32'(bus.err_udf), 32'd0);

        // Overflow: 17 pushes, the last is dropped
        for (int i = 0; i < 17; i++) begin
            wpush(16'h2000 + 16'(i));
            chk("deep8", 32'(bus.wfifo_deepth_eight), (i + 1 >= 8) ? 32'd1 : 32'd0);
            chk("wr_full", 32'(bus.usr_wr_full), (i + 1 >= 16) ? 32'd1 : 32'd0);
            if (i == 15) chk("ovf_not_yet", 32'(bus.err_ovf), 32'd0);
        end
        chk("err_ovf_set", 32'(bus.err_ovf), 32'd1);
        for (int i = 0; i < 16; i++) begin
            wpop();
            chk("full_data", 32'(bus.wfifo_rd_data), 32'h2000 + 32'(i));
        end
        chk("udf_not_yet", 32'(bus.err_udf), 32'd0);
        wpop();
        chk("udf_hold_data", 32'(bus.wfifo_rd_data), 32'h200F);
        chk("err_udf_set", 32'(bus.err_udf), 32'd1);
        tick();
        chk("err_ovf_sticky", 32'(bus.err_ovf), 32'd1);

        reset_and_check("rst1");

        // Two back-to-back read requests; second issues only after first burst
        bus.usr_rd_req = 1'b1;
        tick();
        chk("rd_trig_first_req", 32'(bus.rd_trig), 32'd0);
        tick();
        chk("rd_trig_first", 32'(bus.rd_trig), 32'd1);
        bus.usr_rd_req = 1'b0;
        tick();
        chk("rd_trig_single", 32'(bus.rd_trig), 32'd0);
        for (int i = 0; i < 4; i++) begin
            rpush(16'(i + 1));
            rq.push_back(16'(i + 1));
            chk("rd_trig_busy", 32'(bus.rd_trig), 32'd0);
        end
        tick();
        chk("rd_trig_second", 32'(bus.rd_trig), 32'd1);
        tick();
        chk("rd_trig_second_single", 32'(bus.rd_trig), 32'd0);
        for (int i = 0; i < 4; i++) begin
            rpush(16'(i + 1));
            rq.push_back(16'(i + 1));
        end
        tick();
        chk("rd_trig_none_pending", 32'(bus.rd_trig), 32'd0);
        chk("rd_empty_8", 32'(bus.usr_rd_empty), 32'd0);
        chk("rfifo_full_8", 32'(bus.rfifo_full), 32'd0);

        // Read FIFO at 13 words blocks a pending request until one pop
        for (int i = 5; i < 10; i++) begin
            rpush(16'(i));
            rq.push_back(16'(i));
            if (i == 8) chk("rfifo_full_12", 32'(bus.rfifo_full), 32'd0);
        end
        chk("rfifo_full_13", 32'(bus.rfifo_full), 32'd1);
        bus.usr_rd_req = 1'b1;
        tick();
        bus.usr_rd_req = 1'b0;
        chk("rd_trig_blocked0", 32'(bus.rd_trig), 32'd0);
        tick();
        chk("rd_trig_blocked1", 32'(bus.rd_trig), 32'd0);
        rpop();
        exp_w = rq.pop_front();
        chk("pop1_data", 32'(bus.usr_rd_data), 32'(exp_w));
        chk("pop1_valid", 32'(bus.usr_rd_valid), 32'd1);
        chk("rfifo_full_after_pop", 32'(bus.rfifo_full), 32'd0);
        chk("rd_trig_still_low", 32'(bus.rd_trig), 32'd0);
        tick();
        chk("rd_trig_unblocked", 32'(bus.rd_trig), 32'd1);
        chk("valid_one_cycle", 32'(bus.usr_rd_valid), 32'd0);
        for (int i = 10; i < 14; i++) begin
            rpush(16'(i));
            rq.push_back(16'(i));
        end
        chk("rd_ovf_not_yet", 32'(bus.err_ovf), 32'd0);
        rpush(16'h00EE);
        chk("rd_ovf_set", 32'(bus.err_ovf), 32'd1);
        for (int i = 0; i < 16; i++) begin
            rpop();
            exp_w = rq.pop_front();
            chk("rd_data", 32'(bus.usr_rd_data), 32'(exp_w));
            chk("rd_valid", 32'(bus.usr_rd_valid), 32'd1);
        end
        chk("rd_empty_end", 32'(bus.usr_rd_empty), 32'd1);
        chk("rd_udf_not_yet", 32'(bus.err_udf), 32'd0);
        rpop();
        chk("rd_udf_no_valid", 32'(bus.usr_rd_valid), 32'd0);
        chk("rd_udf_hold_data", 32'(bus.usr_rd_data), 32'h000D);
        chk("rd_udf_set", 32'(bus.err_udf), 32'd1);

        reset_and_check("rst2");

        // Reset in the middle of a burst, then a clean new burst
        for (int i = 0; i < 4; i++) wpush(16'h3000 + 16'(i));
        tick();
        chk("mid_trig", 32'(bus.wr_trig), 32'd1);
        wpop();
        chk("mid_pop0", 32'(bus.wfifo_rd_data), 32'h3000);
        wpop();
        chk("mid_pop1", 32'(bus.wfifo_rd_data), 32'h3001);
        reset_and_check("rst_mid");
        for (int i = 0; i < 4; i++) wpush(16'h4000 + 16'(i));
        chk("new_trig_early", 32'(bus.wr_trig), 32'd0);
        tick();
        chk("new_trig", 32'(bus.wr_trig), 32'd1);
        for (int i = 0; i < 4; i++) begin
            wpop();
            chk("new_data", 32'(bus.wfifo_rd_data), 32'h4000 + 32'(i));
        end
        chk("new_err_udf", 32'(bus.err_udf), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/sdram_fifo_port.md
SDRAM_FIFO_PORT -- requirements
Module: sdram_fifo_port

Interface
REQ-001 SHALL have parameter DATA_W, default 16, FIFO/SDRAM word width.
REQ-002 SHALL have parameter DEPTH, default 16, entries per FIFO; power of two, at least 2*BURST.
REQ-003 SHALL have parameter BURST, default 4, words per SDRAM write or read burst.
REQ-004 SHALL have ports, one per line:
- sclk  in  1  single clock; all logic on its rising edge.
- s_rst  in  1  asynchronous, active-high reset.
- usr_wr_en  in  1  user push into write FIFO.
- usr_wr_data  in  DATA_W  user write word.
- usr_wr_full  out  1  write FIFO full.
- usr_rd_req  in  1  user request for one read burst (pulse).
- usr_rd_en  in  1  user pop from read FIFO.
- usr_rd_data  out  DATA_W  popped word; registered.
- usr_rd_valid  out  1  usr_rd_data valid this cycle.
- usr_rd_empty  out  1  read FIFO empty.
- wr_trig  out  1  one-cycle write-burst request to controller.
- rd_trig  out  1  one-cycle read-burst request to controller.
- wfifo_rd_en  in  1  controller pop from write FIFO.
- wfifo_rd_data  out  DATA_W  popped write word; registered.
- wfifo_deepth_eight  out  1  write FIFO holds at least 8 words.
- rfifo_wr_en  in  1  controller push into read FIFO.
- rfifo_wr_data  in  DATA_W  read word from controller.
- rfifo_full  out  1  read FIFO cannot absorb one more full burst.
- err_ovf  out  1  sticky: push dropped on a full FIFO, either side.
- err_udf  out  1  sticky: pop attempted on an empty FIFO, either side.

Function
REQ-005 Write FIFO SHALL be DEPTH-entry circular buffer; wcnt range 0..DEPTH; pointers wrap modulo DEPTH.
REQ-006 usr_wr_en with wcnt<DEPTH SHALL store word; with wcnt==DEPTH SHALL drop it, leave wcnt unchanged, set err_ovf.
REQ-007 usr_wr_full SHALL equal (wcnt==DEPTH); wfifo_deepth_eight SHALL equal (wcnt>=8); both combinational from registered wcnt.
REQ-008 wfifo_rd_en with wcnt>0 SHALL load head word into wfifo_rd_data on that edge, valid next cycle, held until next pop; with wcnt==0 SHALL leave wfifo_rd_data unchanged and set err_udf.
REQ-009 Simultaneous push and pop on a non-full, non-empty write FIFO SHALL leave wcnt unchanged; at wcnt==0 push proceeds and pop is an underflow; at wcnt==DEPTH pop proceeds and push is dropped.
REQ-010 Write burst FSM states W_IDLE, W_BUSY. W_IDLE with wcnt>=BURST: assert wr_trig one cycle, go W_BUSY, clear wbeat. W_BUSY: count wfifo_rd_en; on BURST-th pop return to W_IDLE. wr_trig SHALL never assert in W_BUSY.
REQ-011 Read FIFO SHALL mirror REQ-005/006/009 with rcnt, pushed by rfifo_wr_en/rfifo_wr_data, popped by usr_rd_en.
REQ-012 rfifo_full SHALL equal (rcnt > DEPTH-BURST); usr_rd_empty SHALL equal (rcnt==0).
REQ-013 usr_rd_en with rcnt>0 SHALL register head word to usr_rd_data and pulse usr_rd_valid next cycle; empty pop SHALL set err_udf, no usr_rd_valid.
REQ-014 usr_rd_req SHALL increment a pending-request counter (saturating at 15); read FSM states R_IDLE, R_BUSY. R_IDLE with pending>0 and rfifo_full==0: assert rd_trig one cycle, decrement pending, go R_BUSY. R_BUSY: count rfifo_wr_en; on BURST-th push return R_IDLE.
REQ-015 usr_rd_req coinciding with rd_trig issue SHALL leave pending unchanged (increment and decrement net zero).
REQ-016 Write and read FSMs SHALL be independent; wr_trig and rd_trig may assert in the same cycle.
REQ-017 err_ovf/err_udf SHALL stay set until reset.

Reset
REQ-018 s_rst high SHALL asynchronously clear pointers, wcnt, rcnt, pending, beat counters, both FSMs to IDLE, wfifo_rd_data and usr_rd_data to 0, wr_trig, rd_trig, usr_rd_valid, err_ovf, err_udf to 0; usr_rd_empty=1, others derived accordingly.
REQ-019 Reset mid-burst SHALL abandon the burst; FIFO contents discarded; no trig for one cycle after deassertion.

Verification
REQ-020 Push 4 words 0x0F10,0x0F55,0x0FAA,0x0F01 -> single wr_trig pulse the cycle after wcnt reaches 4; four wfifo_rd_en pops -> wfifo_rd_data shows same values in order, one cycle after each pop; FSM returns W_IDLE.
REQ-021 Push 17 words, no pops -> usr_wr_full=1 at 16, 17th dropped, err_ovf=1; wfifo_deepth_eight=1 from 8th word.
REQ-022 Two usr_rd_req pulses; controller returns 4 words 0x0001..0x0004 per burst -> two rd_trig pulses, second only after 4th push of first burst; rcnt=8.
REQ-023 Fill read FIFO to 13 words -> rfifo_full=1, pending request holds rd_trig low; pop 1 word -> rfifo_full=0, rd_trig fires next cycle.
REQ-024 Pointer wrap: stream 40 words through write FIFO in bursts of 4 -> data order preserved across wrap, no error flags.
REQ-025 Assert s_rst after 2 of 4 burst pops -> all outputs at REQ-018 values immediately; subsequent 4-word push yields a clean new burst.
